// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit with HI/LO result registers.
//
// Multiply is an unsigned shift-add over the operand magnitudes; divide is an
// unsigned restoring shift-subtract. Both take WIDTH iterations. Signs are fixed
// up in a single FIX cycle, and the result is written to HI/LO on entry to DONE.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   start          launch an operation (ignored while busy)
//   op[1:0]        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b           multiplicand/dividend and multiplier/divisor, sampled on start
//   hi_we, lo_we   direct HI/LO write of wd (ignored while busy)
//   wd             direct write data
//   hi_out, lo_out HI/LO register contents
//   busy           high in CALC and FIX
//   done           one-cycle completion pulse (DONE state)

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;      // raw operands, kept for sign/zero decisions
  logic [WIDTH-1:0]   ma_q, mb_q;    // operand magnitudes
  // Shared accumulator: multiply = {partial product, remaining multiplier bits};
  // divide = {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  // ---------------------------------------------------------------------------
  // Operand magnitudes at the start edge (signed ops only)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_abs_d, b_abs_d;

  always_comb begin
    a_abs_d = a;
    b_abs_d = b;
    if (op[0] && a[WIDTH-1]) a_abs_d = -a;
    if (op[0] && b[WIDTH-1]) b_abs_d = -b;
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right (carry enters the top).
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The shifted remainder is WIDTH+1 bits; when it is >= divisor the true
    // difference is < divisor, so the low WIDTH bits of the difference suffice.
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, mb_q});
    div_sub = div_sh[WIDTH-1:0] - mb_q;

    if (op_q[1]) begin
      if (div_ge) acc_d = {div_sub,            acc_q[WIDTH-2:0], 1'b1};
      else        acc_d = {div_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and final result selection (used in FIX)
  // ---------------------------------------------------------------------------
  logic               neg_res;
  logic               neg_rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi_d, res_lo_d;

  always_comb begin
    neg_res = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_rem = op_q[0] & a_q[WIDTH-1];   // remainder follows the dividend
    prod    = neg_res ? -acc_q : acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    if (neg_res) quo = -quo;
    if (neg_rem) rem = -rem;

    if (!op_q[1]) begin
      res_hi_d = prod[2*WIDTH-1:WIDTH];
      res_lo_d = prod[WIDTH-1:0];
    end else if (b_q == '0) begin
      // Divide by zero: defined result, no trap.
      res_hi_d = a_q;
      res_lo_d = '1;
    end else begin
      // Most-negative / -1 falls out naturally: magnitude 2^(W-1) with equal
      // signs is left un-negated, which reads back as the most-negative value.
      res_hi_d = rem;
      res_lo_d = quo;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, operand/accumulator state and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // Direct writes land now; a result launched on this same edge will
          // overwrite them when it completes.
          if (hi_we) hi_q <= wd;
          if (lo_we) lo_q <= wd;
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            ma_q    <= a_abs_d;
            mb_q    <= b_abs_d;
            acc_q   <= op[1] ? {{WIDTH{1'b0}}, a_abs_d} : {{WIDTH{1'b0}}, b_abs_d};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end

        S_FIX: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus
// randomized operations compared against an arithmetic reference model.

module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd, hi_out, lo_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, C-style truncating division.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
    longint      sx, sy, sq, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = 64'(sx * sy);             eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin el = x / y; eh = x % y; end
      end
      default: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin
          sq = sx / sy;
          sr = sx % sy;
          el = sq[31:0];
          eh = sr[31:0];
        end
      end
    endcase
  endfunction

  // Called at a negedge; the start is taken on the following posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Entered in cycle 1 after the start edge; returns at the negedge of the DONE cycle.
  // poke_start / poke_lo inject a stray start or a lo_we in that cycle number.
  task automatic wait_done(input logic [W-1:0] eh, input logic [W-1:0] el, input string tag,
                           input int poke_start, input int poke_lo);
    int           cyc = 1;
    int           bc  = 0;
    logic [W-1:0] lo_before;
    lo_before = lo_out;
    while (!done && cyc < 60) begin
      if (busy) bc++;
      if (cyc == poke_lo + 1) chk({tag, "_lo_hold"}, lo_out, lo_before);
      start = (cyc == poke_start);
      lo_we = (cyc == poke_lo);
      a = $urandom; b = $urandom; wd = $urandom; op = 2'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lo_we = 1'b0;
    chk({tag, "_lat"},  cyc, W + 2);
    chk({tag, "_busyc"}, bc, W + 1);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_hi"}, hi_out, eh);
    chk({tag, "_lo"}, lo_out, el);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input string tag);
    issue(o, x, y);
    wait_done(eh, el, tag, 0, 0);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    logic [1:0]   o;
    logic [W-1:0] x, y, eh, el;
    int           pulses;

    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Direct writes in IDLE
    hi_we = 1'b1; wd = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi_out, 32'h12345678);
    lo_we = 1'b1; wd = 32'hCAFEF00D;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo_out, 32'hCAFEF00D);
    chk("mtlo_hi_kept", hi_out, 32'h12345678);

    // Directed results
    run(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
    @(negedge clk);
    chk("mult_done_1cyc", done, 0);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu");
    run(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_b2b");
    @(negedge clk);
    run(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg_a");
    @(negedge clk);
    run(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_neg_b");
    @(negedge clk);
    run(2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_by0");
    @(negedge clk);
    run(2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_by0");
    @(negedge clk);
    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
    @(negedge clk);

    // Stray start in cycle 5 is ignored; exactly one done pulse
    issue(2'b01, 32'd1000, 32'hFFFFFFFE);
    wait_done(32'hFFFFFFFF, 32'hFFFFF830, "ign_start", 5, 0);
    count_done(40, pulses);
    chk("ign_start_pulses", pulses, 0);

    // lo_we while busy is dropped; result lands at completion
    issue(2'b00, 32'd6, 32'd9);
    wait_done(32'd0, 32'd54, "lo_busy", 0, 3);
    @(negedge clk);

    // Direct write and start on the same IDLE edge: write now, result wins later
    hi_we = 1'b1; wd = 32'hA5A5A5A5;
    issue(2'b00, 32'd3, 32'd5);
    hi_we = 1'b0;
    chk("same_edge_hi", hi_out, 32'hA5A5A5A5);
    wait_done(32'd0, 32'd15, "same_edge", 0, 0);
    @(negedge clk);

    // Leave nonzero HI/LO, then reset in cycle 10 of an operation
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'b10, 32'd999, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi_out, 0);
    chk("abort_lo", lo_out, 0);
    count_done(40, pulses);
    chk("abort_pulses", pulses, 0);

    // Randomized operations, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'd1;
        2: y = 32'hFFFFFFFF;
        3: y = 32'($urandom_range(2, 50));
        4: x = 32'h80000000;
        default: ;
      endcase
      model(o, x, y, eh, el);
      run(o, x, y, eh, el, $sformatf("rnd%0d_op%0d", i, o));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rnd_done_1cyc", done, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
